// File: rtl/obi_mem_arbiter.sv
// rtl/obi_mem_arbiter.sv - two-master OBI memory port arbiter with in-order response routing
//
// Shares one OBI memory port between the instruction fetcher (master 0) and
// the load/store unit (master 1).
//   CLK, RSTn              : clock, synchronous active-low reset
//   m0_req/addr/gnt        : fetch address phase (read-only master)
//   m0_rvalid/rdata        : fetch response phase
//   m1_req/we/be/addr/wdata: load/store address phase
//   m1_gnt                 : load/store address phase accepted
//   m1_rvalid/rdata        : load/store response phase (reads and writes)
//   mem_req/we/be/addr/wdata, mem_gnt : shared memory address phase
//   mem_rvalid/rdata       : shared memory response phase
//   outst_cnt              : accepted-but-unanswered transaction count
//   err                    : sticky, response seen with no transaction outstanding

module obi_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                           CLK,
  input  logic                           RSTn,
  input  logic                           m0_req,
  input  logic [ADDR_W-1:0]              m0_addr,
  output logic                           m0_gnt,
  output logic                           m0_rvalid,
  output logic [DATA_W-1:0]              m0_rdata,
  input  logic                           m1_req,
  input  logic                           m1_we,
  input  logic [DATA_W/8-1:0]            m1_be,
  input  logic [ADDR_W-1:0]              m1_addr,
  input  logic [DATA_W-1:0]              m1_wdata,
  output logic                           m1_gnt,
  output logic                           m1_rvalid,
  output logic [DATA_W-1:0]              m1_rdata,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [DATA_W/8-1:0]            mem_be,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic                           mem_gnt,
  input  logic                           mem_rvalid,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
  output logic                           err
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               locked_sel_q, locked_sel_d;
  logic               last_winner_q, last_winner_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  // One-bit master ID per FIFO slot.
  logic [MAX_OUTST-1:0] id_q, id_d;

  logic winner;
  logic win_req;
  logic stall;
  logic req_int;
  logic accept;
  logic fifo_empty;
  logic head;
  logic pop;

  // Pointers wrap explicitly so non-power-of-two-free widths (depth 1) still work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Winner selection: in LOCK the held address phase must not change, so the
  // other master is ignored until the memory accepts it.
  always_comb begin
    winner = 1'b0;
    if (state_q == LOCK) begin
      winner = locked_sel_q;
    end else if (m0_req && m1_req) begin
      winner = ~last_winner_q;
    end else begin
      winner = m1_req;
    end
  end

  assign win_req    = winner ? m1_req : m0_req;
  // No bypass: a response arriving in a full cycle does not free a slot until
  // the next cycle.
  assign stall      = (cnt_q == CNT_W'(MAX_OUTST));
  assign req_int    = win_req & ~stall;
  assign accept     = req_int & mem_gnt;
  assign fifo_empty = (cnt_q == '0);
  assign head       = id_q[rd_ptr_q];
  assign pop        = mem_rvalid & ~fifo_empty;

  always_comb begin
    state_d       = state_q;
    locked_sel_d  = locked_sel_q;
    last_winner_d = last_winner_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    id_d          = id_q;

    case (state_q)
      ARB: begin
        if (req_int && !mem_gnt) begin
          state_d      = LOCK;
          locked_sel_d = winner;
        end
      end
      LOCK: begin
        // A stalled cycle cannot be accepted, so the lock persists through it.
        if (accept) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    if (accept) begin
      last_winner_d    = winner;
      id_d[wr_ptr_q]   = winner;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (mem_rvalid && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q       <= ARB;
      locked_sel_q  <= 1'b0;
      last_winner_q <= 1'b1;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      id_q          <= '0;
    end else begin
      state_q       <= state_d;
      locked_sel_q  <= locked_sel_d;
      last_winner_q <= last_winner_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      id_q          <= id_d;
    end
  end

  // Every output is forced low while reset is asserted, including the
  // combinational pass-through paths.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    outst_cnt = '0;
    err       = 1'b0;
    if (RSTn) begin
      mem_req = req_int;
      if (winner) begin
        mem_we    = m1_we;
        mem_be    = m1_be;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
      end else begin
        mem_we    = 1'b0;
        mem_be    = {BE_W{1'b1}};
        mem_addr  = m0_addr;
        mem_wdata = '0;
      end
      m0_gnt    = accept & ~winner;
      m1_gnt    = accept & winner;
      m0_rvalid = pop & ~head;
      m1_rvalid = pop & head;
      m0_rdata  = mem_rdata;
      m1_rdata  = mem_rdata;
      outst_cnt = cnt_q;
      err       = err_q;
    end
  end

endmodule

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
Shares one OBI-style memory port between the instruction fetcher (master 0) and the load/store unit (master 1). It arbitrates address-phase requests with round-robin fairness. It keeps the granted address phase stable until the memory accepts it. It tracks outstanding transactions in an in-order ID FIFO, so each response phase (valid/rdata) is routed back to the master that issued it.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUTST, 2, max accepted-but-unanswered transactions (ID FIFO depth, power of 2, >=1)

Ports:
CLK  in  1  clock
RSTn  in  1  reset, synchronous, active-low
m0_req  in  1  fetch request
m0_addr  in  ADDR_W  fetch address
m0_gnt  out  1  fetch address phase accepted
m0_rvalid  out  1  fetch response valid
m0_rdata  out  DATA_W  fetch response data
m1_req  in  1  data request
m1_we  in  1  data write enable
m1_be  in  DATA_W/8  byte enables
m1_addr  in  ADDR_W  data address
m1_wdata  in  DATA_W  write data
m1_gnt  out  1  data address phase accepted
m1_rvalid  out  1  data response valid (reads and writes)
m1_rdata  out  DATA_W  data response
mem_req  out  1  request to memory
mem_we  out  1  write enable to memory
mem_be  out  DATA_W/8  byte enables to memory
mem_addr  out  ADDR_W  address to memory
mem_wdata  out  DATA_W  write data to memory
mem_gnt  in  1  memory accepted address phase
mem_rvalid  in  1  memory response valid
mem_rdata  in  DATA_W  memory response data
outst_cnt  out  $clog2(MAX_OUTST+1)  current outstanding count
err  out  1  sticky: mem_rvalid received with ID FIFO empty

Behaviour:
- Reset: lock=0, last_winner=1 (so master 0 wins first tie), FIFO empty, outst_cnt=0, err=0. All outputs driven 0 while RSTn=0. rdata outputs are don't-care when rvalid=0.
- Arbitration FSM, two states:
  - ARB: winner chosen combinationally. Single requester wins. If both request, the master != last_winner wins.
  - LOCK: winner = locked_sel. Requests from the other master are ignored.
- Transitions:
  - ARB -> LOCK when mem_req=1 and mem_gnt=0. Store locked_sel = winner.
  - LOCK -> ARB on the cycle mem_gnt=1.
  - last_winner updates on every accepted transfer (mem_req & mem_gnt).
- Address-phase muxing is zero-latency combinational: mem_req = winner's req & !stall. mem_addr/we/be/wdata come from the winner. Master 0 drives we=0, be=all-ones, wdata=0.
- mX_gnt = mem_gnt & mem_req & (winner==X). At most one gnt per cycle.
- Stall: when outst_cnt == MAX_OUTST, mem_req=0 and both gnt=0. This holds even if mem_rvalid=1 in the same cycle (no bypass). Stall does not change FSM state. If stall occurs in LOCK, the lock is kept.
- ID FIFO:
  - Push winner ID on mem_req & mem_gnt.
  - Pop on mem_rvalid. The head ID selects the destination: mX_rvalid = mem_rvalid & (head==X).
  - mX_rdata = mem_rdata, passed straight through.
  - Push and pop in the same cycle: count unchanged, both operations performed.
  - Pointers wrap modulo MAX_OUTST.
- mem_rvalid with FIFO empty: no mX_rvalid asserted, err set to 1. err stays set until reset.
- Responses are strictly in order. Memory is required to answer in acceptance order.
- Reset mid-transaction drops all outstanding IDs. Late responses after reset set err.
- Master-side OBI rule: req and address-phase signals stay stable until gnt. The arbiter relies on this and does not check it.

Test Plan:
- Single fetch: m0_req=1 addr=0x100, mem_gnt=1 same cycle, mem_rvalid 1 cycle later with rdata=0xDEADBEEF -> m0_gnt=1 in cycle 0; m0_rvalid=1 with rdata=0xDEADBEEF in cycle 1; m1_rvalid=0; outst_cnt goes 0->1->0.
- Contention: m0_req and m1_req held high, mem_gnt=1 every cycle -> grants alternate m0,m1,m0,m1. Responses arrive in order and are routed to matching masters.
- Lock: m1 write addr=0x200 wins with mem_gnt=0 for 3 cycles while m0_req=1 -> mem_addr stays 0x200 with mem_we=1 for all 3 cycles; m0_gnt=0; m1_gnt=1 on cycle 3; m0 wins on the next cycle.
- Full stall: MAX_OUTST=2, two grants with no response -> outst_cnt=2 and mem_req=0 despite pending requests. With mem_rvalid=1 and a new request in the same cycle, no grant that cycle; grant resumes the following cycle.
- Push/pop same cycle: outst_cnt=1 (head=m0), new m1 grant and mem_rvalid together -> m0_rvalid=1, outst_cnt stays 1, next response goes to m1.
- Spurious response: mem_rvalid=1 with empty FIFO -> m0_rvalid=m1_rvalid=0, err=1 and stays 1 until RSTn=0.
